// File: rtl/mprj_pad_cfg_sequencer.sv
// Shadow configuration store for the mprj pad ring plus a serial loader that streams every
// pad word down the control chain (last pad first, MSB first) and then strobes load.
module mprj_pad_cfg_sequencer #(
   parameter int                  NUM_PADS  = 38,
   parameter int                  CFG_BITS  = 13,
   parameter int                  CLK_DIV   = 2,
   parameter logic [CFG_BITS-1:0] CFG_RESET = 13'h0403,
   localparam int                 AW        = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                cfg_wr_en,
   input  logic [AW-1:0]       cfg_wr_addr,
   input  logic [CFG_BITS-1:0] cfg_wr_data,
   output logic                cfg_wr_err,
   input  logic [AW-1:0]       cfg_rd_addr,
   output logic [CFG_BITS-1:0] cfg_rd_data,
   input  logic                start,
   output logic                busy,
   output logic                done,
   output logic                serial_clock,
   output logic                serial_data,
   output logic                serial_load
);

   localparam int TOTAL = NUM_PADS * CFG_BITS;
   localparam int BCW   = $clog2(TOTAL + 1);
   localparam int PCW   = $clog2(2 * CLK_DIV);

   localparam logic [PCW-1:0] PH_LAST  = PCW'(2 * CLK_DIV - 1);
   localparam logic [PCW-1:0] PH_HIGH  = PCW'(CLK_DIV);
   localparam logic [PCW-1:0] LD_LAST  = PCW'(CLK_DIV - 1);
   localparam logic [BCW-1:0] BIT_LAST = BCW'(TOTAL - 1);
   localparam logic [BCW-1:0] BIT_END  = BCW'(TOTAL);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_LOAD, S_DONE} state_t;

   state_t              state_q, state_d;
   logic [BCW-1:0]      bit_cnt_q, bit_cnt_d;
   logic [PCW-1:0]      ph_cnt_q, ph_cnt_d;
   logic [TOTAL-1:0]    snap_q, snap_d;
   logic [CFG_BITS-1:0] shadow_q [NUM_PADS];
   logic [CFG_BITS-1:0] shadow_d [NUM_PADS];
   logic                done_q, done_d;
   logic                wr_err_q, wr_err_d;

   logic                wr_addr_ok;
   logic                rd_addr_ok;
   logic                wr_ok;
   logic [TOTAL-1:0]    shadow_flat;

   assign wr_addr_ok = (32'(cfg_wr_addr) < NUM_PADS);
   assign rd_addr_ok = (32'(cfg_rd_addr) < NUM_PADS);
   assign wr_ok      = cfg_wr_en && (state_q == S_IDLE) && wr_addr_ok;

   // Pad NUM_PADS-1 lands in the top bits so the stream can always shift out of the MSB.
   always_comb begin
      shadow_flat = '0;
      for (int p = 0; p < NUM_PADS; p++) begin
         shadow_flat[p*CFG_BITS +: CFG_BITS] = shadow_q[p];
      end
   end

   always_comb begin
      for (int p = 0; p < NUM_PADS; p++) begin
         shadow_d[p] = shadow_q[p];
      end
      if (wr_ok) begin
         shadow_d[cfg_wr_addr] = cfg_wr_data;
      end
      wr_err_d = cfg_wr_en && !wr_ok;
      done_d   = (state_q == S_DONE);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= S_IDLE;
         bit_cnt_q <= '0;
         ph_cnt_q  <= '0;
         snap_q    <= '0;
         done_q    <= 1'b0;
         wr_err_q  <= 1'b0;
         for (int p = 0; p < NUM_PADS; p++) begin
            shadow_q[p] <= CFG_RESET;
         end
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         ph_cnt_q  <= ph_cnt_d;
         snap_q    <= snap_d;
         done_q    <= done_d;
         wr_err_q  <= wr_err_d;
         for (int p = 0; p < NUM_PADS; p++) begin
            shadow_q[p] <= shadow_d[p];
         end
      end
   end

   // The snapshot reads shadow_q, so a write committing on the accept edge is not in the stream.
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      ph_cnt_d  = ph_cnt_q;
      snap_d    = snap_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d   = S_SHIFT;
               bit_cnt_d = '0;
               ph_cnt_d  = '0;
               snap_d    = shadow_flat;
            end
         end
         S_SHIFT: begin
            if (ph_cnt_q == PH_LAST) begin
               ph_cnt_d = '0;
               snap_d   = snap_q << 1;
               if (bit_cnt_q == BIT_LAST) begin
                  state_d   = S_LOAD;
                  bit_cnt_d = BIT_END;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end else begin
               ph_cnt_d = ph_cnt_q + 1'b1;
            end
         end
         S_LOAD: begin
            if (ph_cnt_q == LD_LAST) begin
               state_d  = S_DONE;
               ph_cnt_d = '0;
            end else begin
               ph_cnt_d = ph_cnt_q + 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      busy         = (state_q != S_IDLE);
      serial_clock = (state_q == S_SHIFT) && (ph_cnt_q >= PH_HIGH);
      serial_data  = (state_q == S_SHIFT) && snap_q[TOTAL-1];
      serial_load  = (state_q == S_LOAD);
      done         = done_q;
      cfg_wr_err   = wr_err_q;
      cfg_rd_data  = rd_addr_ok ? shadow_q[cfg_rd_addr] : '0;
   end

endmodule

// File: tb/tb_mprj_pad_cfg_sequencer.sv
// Directed bench: two 2-pad x 4-bit loaders (CLK_DIV 1 and 3) driven in parallel, plus a
// 3-pad instance whose 2-bit address can express an out-of-range pad.
module tb_mprj_pad_cfg_sequencer;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       wr_en = 1'b0;
   logic [0:0] wr_addr = '0;
   logic [3:0] wr_data = '0;
   logic [0:0] rd_addr = '0;
   logic       start = 1'b0;

   logic       a_err, a_busy, a_done, a_sclk, a_sdat, a_sload;
   logic [3:0] a_rd;
   logic       b_err, b_busy, b_done, b_sclk, b_sdat, b_sload;
   logic [3:0] b_rd;

   logic       c_wr_en = 1'b0;
   logic [1:0] c_wr_addr = '0;
   logic [3:0] c_wr_data = '0;
   logic [1:0] c_rd_addr = '0;
   logic       c_start = 1'b0;
   logic       c_err, c_busy, c_done, c_sclk, c_sdat, c_sload;
   logic [3:0] c_rd;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   mprj_pad_cfg_sequencer #(.NUM_PADS(2), .CFG_BITS(4), .CLK_DIV(1), .CFG_RESET(4'h3)) u_a (
      .clock(clock), .reset(reset), .cfg_wr_en(wr_en), .cfg_wr_addr(wr_addr),
      .cfg_wr_data(wr_data), .cfg_wr_err(a_err), .cfg_rd_addr(rd_addr), .cfg_rd_data(a_rd),
      .start(start), .busy(a_busy), .done(a_done), .serial_clock(a_sclk),
      .serial_data(a_sdat), .serial_load(a_sload));

   mprj_pad_cfg_sequencer #(.NUM_PADS(2), .CFG_BITS(4), .CLK_DIV(3), .CFG_RESET(4'h3)) u_b (
      .clock(clock), .reset(reset), .cfg_wr_en(wr_en), .cfg_wr_addr(wr_addr),
      .cfg_wr_data(wr_data), .cfg_wr_err(b_err), .cfg_rd_addr(rd_addr), .cfg_rd_data(b_rd),
      .start(start), .busy(b_busy), .done(b_done), .serial_clock(b_sclk),
      .serial_data(b_sdat), .serial_load(b_sload));

   mprj_pad_cfg_sequencer #(.NUM_PADS(3), .CFG_BITS(4), .CLK_DIV(1), .CFG_RESET(4'h3)) u_c (
      .clock(clock), .reset(reset), .cfg_wr_en(c_wr_en), .cfg_wr_addr(c_wr_addr),
      .cfg_wr_data(c_wr_data), .cfg_wr_err(c_err), .cfg_rd_addr(c_rd_addr), .cfg_rd_data(c_rd),
      .start(c_start), .busy(c_busy), .done(c_done), .serial_clock(c_sclk),
      .serial_data(c_sdat), .serial_load(c_sload));

   // Results gathered by run_monitor for the scenario tasks to judge.
   logic a_bits[$];
   logic b_bits[$];
   int   a_done_at[$];
   int   a_busy_n, b_busy_n, a_loads, b_loads, a_dones, b_dones;
   int   a_load_start, a_last_fall, a_done_bad, b_done_bad;
   int   a_err_n, b_err_n, a_err_cyc;
   int   b_runs, b_bad_runs;
   bit   mon_ok;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic run_monitor(input int max_cyc, input int need_a, input int need_b,
                              input int wr_at, input int drop_at);
      logic a_prev_clk, a_prev_busy, b_prev_clk, b_prev_busy;
      int   b_run;
      a_bits.delete(); b_bits.delete(); a_done_at.delete();
      a_busy_n = 0; b_busy_n = 0; a_loads = 0; b_loads = 0; a_dones = 0; b_dones = 0;
      a_load_start = -1; a_last_fall = -1; a_done_bad = 0; b_done_bad = 0;
      a_err_n = 0; b_err_n = 0; a_err_cyc = -1; b_runs = 0; b_bad_runs = 0; b_run = 0;
      mon_ok = 1'b0;
      a_prev_clk = a_sclk; a_prev_busy = a_busy; b_prev_clk = b_sclk; b_prev_busy = b_busy;
      for (int cyc = 1; cyc <= max_cyc; cyc++) begin
         tick();
         if (cyc == 1) wr_en = 1'b0;
         if (cyc == drop_at) start = 1'b0;
         if (cyc == wr_at) begin
            wr_en = 1'b1; wr_addr = 1'b0; wr_data = 4'hF;
         end
         if (cyc == wr_at + 1) wr_en = 1'b0;
         if (a_busy) a_busy_n++;
         if (b_busy) b_busy_n++;
         if (!a_prev_clk && a_sclk) a_bits.push_back(a_sdat);
         if (!b_prev_clk && b_sclk) b_bits.push_back(b_sdat);
         if (a_prev_clk && !a_sclk) a_last_fall = cyc;
         if (a_sload) begin
            if (a_loads == 0) a_load_start = cyc;
            a_loads++;
         end
         if (b_sload) b_loads++;
         if (a_done) begin
            a_dones++; a_done_at.push_back(cyc);
            if (a_busy || !a_prev_busy) a_done_bad++;
         end
         if (b_done) begin
            b_dones++;
            if (b_busy || !b_prev_busy) b_done_bad++;
         end
         if (a_err) begin a_err_n++; a_err_cyc = cyc; end
         if (b_err) b_err_n++;
         if (b_busy && !b_sload && b_loads == 0) begin
            if (b_run > 0 && b_sclk == b_prev_clk) b_run++;
            else begin
               if (b_run > 0) begin b_runs++; if (b_run != 3) b_bad_runs++; end
               b_run = 1;
            end
         end else if (b_run > 0) begin
            b_runs++; if (b_run != 3) b_bad_runs++;
            b_run = 0;
         end
         a_prev_clk = a_sclk; a_prev_busy = a_busy; b_prev_clk = b_sclk; b_prev_busy = b_busy;
         if (a_dones >= need_a && b_dones >= need_b) begin
            mon_ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      checks++;
      if ({a_busy, a_done, a_err, a_sclk, a_sdat, a_sload} !== 6'b0) begin
         errors++; $display("FAIL reset_outputs_a got %b want 000000", {a_busy, a_done, a_err, a_sclk, a_sdat, a_sload});
      end
      checks++;
      if ({b_busy, b_done, b_err, b_sclk, b_sdat, b_sload} !== 6'b0) begin
         errors++; $display("FAIL reset_outputs_b got %b want 000000", {b_busy, b_done, b_err, b_sclk, b_sdat, b_sload});
      end
      for (int p = 0; p < 2; p++) begin
         rd_addr = 1'(p); #1;
         checks++;
         if (a_rd !== 4'h3) begin errors++; $display("FAIL reset_shadow_a pad%0d got %h want 3", p, a_rd); end
         checks++;
         if (b_rd !== 4'h3) begin errors++; $display("FAIL reset_shadow_b pad%0d got %h want 3", p, b_rd); end
      end
   endtask

   task automatic test_write();
      wr_en = 1'b1; wr_addr = 1'b1; wr_data = 4'hA;
      tick();
      rd_addr = 1'b1; #1;
      checks++;
      if (a_rd !== 4'hA) begin errors++; $display("FAIL write_pad1_next_cycle got %h want a", a_rd); end
      wr_addr = 1'b0; wr_data = 4'h5;
      tick();
      wr_en = 1'b0;
      checks++;
      if (a_err !== 1'b0 || b_err !== 1'b0) begin errors++; $display("FAIL write_idle_err got %b%b want 00", a_err, b_err); end
      rd_addr = 1'b0; #1;
      checks++;
      if (a_rd !== 4'h5 || b_rd !== 4'h5) begin errors++; $display("FAIL write_pad0 got %h/%h want 5/5", a_rd, b_rd); end
   endtask

   task automatic test_transfer();
      logic [7:0] got_a, got_b;
      start = 1'b1;
      run_monitor(300, 1, 1, 4, 1);
      checks++;
      if (!mon_ok) begin errors++; $display("FAIL transfer_timeout got done=%0d/%0d want 1/1", a_dones, b_dones); end
      got_a = '0; got_b = '0;
      foreach (a_bits[i]) got_a = {got_a[6:0], a_bits[i]};
      foreach (b_bits[i]) got_b = {got_b[6:0], b_bits[i]};
      checks++;
      if (a_bits.size() != 8 || got_a !== 8'b10100101) begin
         errors++; $display("FAIL stream_a got %b (n=%0d) want 10100101", got_a, a_bits.size());
      end
      checks++;
      if (a_busy_n != 18) begin errors++; $display("FAIL busy_len_a got %0d want 18", a_busy_n); end
      checks++;
      if (a_loads != 1 || a_load_start != a_last_fall) begin
         errors++; $display("FAIL load_a got len=%0d at %0d want len=1 at %0d", a_loads, a_load_start, a_last_fall);
      end
      checks++;
      if (a_dones != 1 || a_done_at[0] != 19 || a_done_bad != 0) begin
         errors++; $display("FAIL done_a got n=%0d bad=%0d want n=1 at cycle 19 with busy falling", a_dones, a_done_bad);
      end
      checks++;
      if (a_err_n != 1 || a_err_cyc != 5 || b_err_n != 1) begin
         errors++; $display("FAIL busy_write_err got a=%0d@%0d b=%0d want 1@5 1", a_err_n, a_err_cyc, b_err_n);
      end
      rd_addr = 1'b0; #1;
      checks++;
      if (a_rd !== 4'h5 || b_rd !== 4'h5) begin errors++; $display("FAIL busy_write_no_change got %h/%h want 5/5", a_rd, b_rd); end
      checks++;
      if (b_bits.size() != 8 || got_b !== 8'b10100101) begin
         errors++; $display("FAIL stream_b got %b (n=%0d) want 10100101", got_b, b_bits.size());
      end
      checks++;
      if (b_busy_n != 52) begin errors++; $display("FAIL busy_len_b got %0d want 52", b_busy_n); end
      checks++;
      if (b_runs != 16 || b_bad_runs != 0) begin
         errors++; $display("FAIL phase_len_b got runs=%0d bad=%0d want 16 0", b_runs, b_bad_runs);
      end
      checks++;
      if (b_loads != 3 || b_dones != 1 || b_done_bad != 0) begin
         errors++; $display("FAIL load_done_b got load=%0d done=%0d bad=%0d want 3 1 0", b_loads, b_dones, b_done_bad);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [15:0] got_a;
      logic [7:0]  got_b;
      start = 1'b1; wr_en = 1'b1; wr_addr = 1'b1; wr_data = 4'hC;
      run_monitor(300, 2, 1, -10, 25);
      checks++;
      if (!mon_ok) begin errors++; $display("FAIL b2b_timeout got done=%0d/%0d want 2/1", a_dones, b_dones); end
      got_a = '0; got_b = '0;
      foreach (a_bits[i]) got_a = {got_a[14:0], a_bits[i]};
      for (int i = 0; i < 8 && i < b_bits.size(); i++) got_b = {got_b[6:0], b_bits[i]};
      checks++;
      if (a_bits.size() != 16 || got_a !== 16'b1010010111000101) begin
         errors++; $display("FAIL b2b_stream_a got %b (n=%0d) want 1010010111000101", got_a, a_bits.size());
      end
      checks++;
      if (a_done_at.size() != 2 || a_done_at[0] != 19 || a_done_at[1] != 38 || a_busy_n != 36) begin
         errors++; $display("FAIL b2b_timing_a got dones=%0d busy=%0d want at 19,38 busy 36", a_done_at.size(), a_busy_n);
      end
      checks++;
      if (a_err_n != 0 || b_err_n != 0) begin errors++; $display("FAIL start_write_err got %0d/%0d want 0/0", a_err_n, b_err_n); end
      checks++;
      if (got_b !== 8'b10100101 || b_dones != 1) begin
         errors++; $display("FAIL b2b_snapshot_b got %b done=%0d want 10100101 1", got_b, b_dones);
      end
      rd_addr = 1'b1; #1;
      checks++;
      if (a_rd !== 4'hC || b_rd !== 4'hC) begin errors++; $display("FAIL start_write_commit got %h/%h want c/c", a_rd, b_rd); end
      tick();
   endtask

   task automatic test_out_of_range();
      c_wr_en = 1'b1; c_wr_addr = 2'd3; c_wr_data = 4'hF;
      tick();
      c_wr_en = 1'b0;
      checks++;
      if (c_err !== 1'b1) begin errors++; $display("FAIL oor_err_pulse got %b want 1", c_err); end
      tick();
      checks++;
      if (c_err !== 1'b0) begin errors++; $display("FAIL oor_err_single got %b want 0", c_err); end
      for (int p = 0; p < 4; p++) begin
         c_rd_addr = 2'(p); #1;
         checks++;
         if (c_rd !== ((p == 3) ? 4'h0 : 4'h3)) begin
            errors++; $display("FAIL oor_readback pad%0d got %h want %h", p, c_rd, (p == 3) ? 4'h0 : 4'h3);
         end
      end
      c_wr_en = 1'b1; c_wr_addr = 2'd2; c_wr_data = 4'h9;
      tick();
      c_wr_en = 1'b0; c_rd_addr = 2'd2; #1;
      checks++;
      if (c_err !== 1'b0 || c_rd !== 4'h9) begin errors++; $display("FAIL top_pad_write got err=%b data=%h want 0 9", c_err, c_rd); end
   endtask

   task automatic test_reset_abort();
      int   rises, bad;
      logic prev;
      start = 1'b1;
      tick();
      start = 1'b0;
      rises = 0; prev = a_sclk;
      for (int i = 0; i < 40 && rises < 5; i++) begin
         tick();
         if (!prev && a_sclk) rises++;
         prev = a_sclk;
      end
      checks++;
      if (rises != 5) begin errors++; $display("FAIL abort_reach_bit5 got %0d want 5", rises); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if ({a_busy, a_done, a_err, a_sclk, a_sdat, a_sload, b_busy, b_sclk, b_sdat, b_sload} !== 10'b0) begin
         errors++; $display("FAIL abort_outputs got %b want 0000000000",
                            {a_busy, a_done, a_err, a_sclk, a_sdat, a_sload, b_busy, b_sclk, b_sdat, b_sload});
      end
      bad = 0;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (a_sload || b_sload || a_busy || b_busy || a_done || b_done) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL abort_no_load got %0d active cycles want 0", bad); end
      for (int p = 0; p < 2; p++) begin
         rd_addr = 1'(p); #1;
         checks++;
         if (a_rd !== 4'h3 || b_rd !== 4'h3) begin
            errors++; $display("FAIL abort_shadow pad%0d got %h/%h want 3/3", p, a_rd, b_rd);
         end
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_transfer();
      test_back_to_back();
      test_out_of_range();
      test_reset_abort();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
